// File: rtl/bus_level_monitor_if.sv
// ============================================================================
// bus_level_monitor_if : bus, clear and status signals of bus_level_monitor
// Revision 1.0
// ============================================================================
`default_nettype none

interface bus_level_monitor_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  logic [N-1:0]  BUS;
  logic          CLEAR;
  logic          LEVEL_ZERO;
  logic          LEVEL_ONE;
  logic          RISE;
  logic          FALL;
  logic [CW-1:0] TOGGLES;
  logic          ERR;

  modport master (
    output BUS, CLEAR,
    input  LEVEL_ZERO, LEVEL_ONE, RISE, FALL, TOGGLES, ERR
  );

  modport slave (
    input  BUS, CLEAR,
    output LEVEL_ZERO, LEVEL_ONE, RISE, FALL, TOGGLES, ERR
  );
endinterface

`default_nettype wire

// File: rtl/bus_level_monitor.sv
// ============================================================================
// bus_level_monitor : debounced all-zeroes/all-ones level detector with
// edge pulses, saturating transition count and sticky mixed-value error.
// Revision 1.0
// ============================================================================
`default_nettype none

module bus_level_monitor #(
  parameter int N      = 4,
  parameter int STABLE = 3,
  parameter int CW     = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  bus_level_monitor_if.slave bus_if
);

  localparam int RW = $clog2(STABLE + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE);

  typedef enum logic [1:0] {
    CLS_M = 2'd0,
    CLS_Z = 2'd1,
    CLS_O = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    ST_UNK  = 2'd0,
    ST_ZERO = 2'd1,
    ST_ONE  = 2'd2
  } state_e;

  logic [N-1:0]  bus_q;
  logic          vld_q;
  cls_e          cls;
  cls_e          cand_q, cand_d;
  logic [RW-1:0] run_q, run_d;
  state_e        state_q, state_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] tog_q, tog_d;
  logic          err_q, err_d;

  always_comb begin
    if (bus_q == '0)      cls = CLS_Z;
    else if (bus_q == '1) cls = CLS_O;
    else                  cls = CLS_M;
  end

  always_comb begin
    cand_d  = cand_q;
    run_d   = run_q;
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    tog_d   = tog_q;
    err_d   = err_q;

    // bus_q holds a real sample only from the second edge after reset
    if (vld_q) begin
      if (cls == cand_q) begin
        if (run_q != RUN_MAX) run_d = run_q + RW'(1);
      end else begin
        cand_d = cls;
        run_d  = RW'(1);
      end

      if (run_d == RUN_MAX) begin
        case (cand_d)
          CLS_Z: if (state_q != ST_ZERO) begin
            state_d = ST_ZERO;
            fall_d  = (state_q == ST_ONE);
          end
          CLS_O: if (state_q != ST_ONE) begin
            state_d = ST_ONE;
            rise_d  = (state_q == ST_ZERO);
          end
          default: if (state_q != ST_UNK) state_d = ST_UNK;
        endcase
      end

      if (cls == CLS_M && state_q != ST_UNK) err_d = 1'b1;
    end

    if ((rise_d || fall_d) && tog_q != '1) tog_d = tog_q + CW'(1);

    if (bus_if.CLEAR) begin
      tog_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus_q   <= '0;
      vld_q   <= 1'b0;
      cand_q  <= CLS_M;
      run_q   <= '0;
      state_q <= ST_UNK;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tog_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      bus_q   <= bus_if.BUS;
      vld_q   <= 1'b1;
      cand_q  <= cand_d;
      run_q   <= run_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tog_q   <= tog_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.LEVEL_ZERO = (state_q == ST_ZERO);
  assign bus_if.LEVEL_ONE  = (state_q == ST_ONE);
  assign bus_if.RISE       = rise_q;
  assign bus_if.FALL       = fall_q;
  assign bus_if.TOGGLES    = tog_q;
  assign bus_if.ERR        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_level_monitor.sv
// ============================================================================
// tb_bus_level_monitor : directed scoreboard bench; two instances share the
// stimulus, one with an 8-bit counter and one with a 2-bit counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bus_level_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_level_monitor_if #(.N(4), .CW(8)) ifa ();
  bus_level_monitor_if #(.N(4), .CW(2)) ifb ();

  bus_level_monitor #(.N(4), .STABLE(3), .CW(8)) u_dut_a (
    .CLK    (clk),
    .RESET  (rst),
    .bus_if (ifa.slave)
  );

  bus_level_monitor #(.N(4), .STABLE(3), .CW(2)) u_dut_b (
    .CLK    (clk),
    .RESET  (rst),
    .bus_if (ifb.slave)
  );

  typedef struct packed {
    logic       lz;
    logic       lo;
    logic       ri;
    logic       fa;
    logic [7:0] tog;
    logic [1:0] tog2;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   idx_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_n = 0;

  task automatic S(input logic [3:0] b, input logic c, input logic r,
                   input logic lz, input logic lo, input logic ri, input logic fa,
                   input logic [7:0] tog, input logic [1:0] tog2, input logic err);
    exp_t e;
    @(posedge clk);
    #2;
    rst       = r;
    ifa.BUS   = b;
    ifb.BUS   = b;
    ifa.CLEAR = c;
    ifb.CLEAR = c;
    e = '{lz: lz, lo: lo, ri: ri, fa: fa, tog: tog, tog2: tog2, err: err};
    exp_q.push_back(e);
    idx_q.push_back(step_n);
    step_n++;
  endtask

  // Monitor: the DUT presents a fresh status word after every edge
  initial begin
    exp_t e, a;
    int   id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        id = idx_q.pop_front();
        a = '{lz: ifa.LEVEL_ZERO, lo: ifa.LEVEL_ONE, ri: ifa.RISE, fa: ifa.FALL,
              tog: ifa.TOGGLES, tog2: ifb.TOGGLES, err: ifa.ERR};
        checks++;
        if (a !== e || ifb.LEVEL_ZERO !== e.lz || ifb.LEVEL_ONE !== e.lo ||
            ifb.RISE !== e.ri || ifb.FALL !== e.fa || ifb.ERR !== e.err) begin
          errors++;
          $display("FAIL step%0d actual lz=%b lo=%b rise=%b fall=%b tog=%0d togB=%0d err=%b (B lz=%b lo=%b r=%b f=%b e=%b) required lz=%b lo=%b rise=%b fall=%b tog=%0d togB=%0d err=%b",
                   id, a.lz, a.lo, a.ri, a.fa, a.tog, a.tog2, a.err,
                   ifb.LEVEL_ZERO, ifb.LEVEL_ONE, ifb.RISE, ifb.FALL, ifb.ERR,
                   e.lz, e.lo, e.ri, e.fa, e.tog, e.tog2, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.BUS = '0; ifb.BUS = '0; ifa.CLEAR = 1'b0; ifb.CLEAR = 1'b0;

    // reset with bus at zero, then ZERO confirmed on the 4th edge after release
    repeat (5) S(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) S(4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    S(4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // ZERO -> ONE with RISE, then ONE -> ZERO with FALL
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    S(4'hF, 0, 0, 0, 1, 1, 0, 1, 1, 0);
    repeat (2) S(4'hF, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    repeat (3) S(4'h0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    S(4'h0, 0, 0, 1, 0, 0, 1, 2, 2, 0);
    S(4'h0, 0, 0, 1, 0, 0, 0, 2, 2, 0);
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 2, 2, 0);
    S(4'hF, 0, 0, 0, 1, 1, 0, 3, 3, 0);
    S(4'hF, 0, 0, 0, 1, 0, 0, 3, 3, 0);
    // two-sample zero glitch while ONE: ignored
    repeat (2) S(4'h0, 0, 0, 0, 1, 0, 0, 3, 3, 0);
    repeat (4) S(4'hF, 0, 0, 0, 1, 0, 0, 3, 3, 0);
    // mixed value: ERR one edge after sampling, UNK after 4 edges, then CLEAR
    S(4'h5, 0, 0, 0, 1, 0, 0, 3, 3, 0);
    repeat (2) S(4'h5, 0, 0, 0, 1, 0, 0, 3, 3, 1);
    S(4'h5, 0, 0, 0, 0, 0, 0, 3, 3, 1);
    S(4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) S(4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    S(4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // alternating levels: counter B saturates at 3
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    S(4'hF, 0, 0, 0, 1, 1, 0, 1, 1, 0);
    S(4'hF, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    repeat (3) S(4'h0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
    S(4'h0, 0, 0, 1, 0, 0, 1, 2, 2, 0);
    S(4'h0, 0, 0, 1, 0, 0, 0, 2, 2, 0);
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 2, 2, 0);
    S(4'hF, 0, 0, 0, 1, 1, 0, 3, 3, 0);
    S(4'hF, 0, 0, 0, 1, 0, 0, 3, 3, 0);
    repeat (3) S(4'h0, 0, 0, 0, 1, 0, 0, 3, 3, 0);
    S(4'h0, 0, 0, 1, 0, 0, 1, 4, 3, 0);
    S(4'h0, 0, 0, 1, 0, 0, 0, 4, 3, 0);
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 4, 3, 0);
    S(4'hF, 0, 0, 0, 1, 1, 0, 5, 3, 0);
    S(4'hF, 0, 0, 0, 1, 0, 0, 5, 3, 0);
    repeat (3) S(4'h0, 0, 0, 0, 1, 0, 0, 5, 3, 0);
    S(4'h0, 0, 0, 1, 0, 0, 1, 6, 3, 0);
    S(4'h0, 0, 0, 1, 0, 0, 0, 6, 3, 0);
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 6, 3, 0);
    // CLEAR coincident with RISE: counters zero, pulse still seen
    S(4'hF, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    S(4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) S(4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    S(4'h0, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    // reset with run at 2 toward ONE, then full latency and no RISE
    repeat (3) S(4'hF, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    S(4'hF, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) S(4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) S(4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
